// File: rtl/matmul_host_sequencer_pkg.sv
// Shared constants and FSM encoding for the matmul host sequencer.
package matmul_host_sequencer_pkg;

  localparam int DWIDTH = 16;
  localparam int SIZE   = 8;
  localparam int AWIDTH = 7;
  localparam int WR_LAT = 2;
  localparam int RD_LAT = 3;
  localparam int ROW_W  = SIZE * DWIDTH;

  typedef enum logic [2:0] {
    IDLE,
    PREP_WR,
    LOAD_A,
    LOAD_B,
    DRAIN_WR,
    COMPUTE,
    GAP,
    READ_C
  } state_t;

endpackage

// File: rtl/matmul_host_sequencer_rdfifo.sv
// Synchronous read-return FIFO with occupancy count; push and pop may coincide.
module matmul_seq_rdfifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // NOTE: storage is not reset; head only matters while count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer: loads A/B rows into the matmul BRAMs, runs the multiply,
// and streams C rows back through a credit-limited read FIFO.
module matmul_host_sequencer
  import matmul_host_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_go,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  out_data,
  output logic              busy,
  output logic              error,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [ROW_W-1:0]  data_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul,
  input  logic              done_mat_mul,
  input  logic [ROW_W-1:0]  data_from_out_mat
);

  localparam int RW = $clog2(SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state, state_next;
  logic             accept, issue, tap, pop, timed_out, credit_ok;
  logic             fifo_empty;
  logic [RW-1:0]    row_cnt, iss_cnt, pop_cnt;
  logic [TW-1:0]    cyc_cnt;
  logic [CW-1:0]    out_cnt, fifo_count;
  logic [WR_LAT-1:0] wr_vld, wr_isb;
  logic [ROW_W-1:0] wr_dat [WR_LAT];
  logic [RD_LAT-1:0] rd_pipe;
  logic [ROW_W-1:0] fifo_head;

  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign tap       = rd_pipe[RD_LAT-1];
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign pop       = out_valid && out_ready;
  assign credit_ok = ((CW+1)'(out_cnt) + (CW+1)'(fifo_count)) < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next              = state;
    in_ready                = 1'b0;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    start_mat_mul           = 1'b0;
    we_c                    = 1'b0;
    addr_pi                 = '0;
    issue                   = 1'b0;
    timed_out               = 1'b0;
    case (state)
      IDLE:    if (cmd_go) state_next = PREP_WR;
      PREP_WR: begin
        enable_writing_to_mem = 1'b1;
        state_next            = LOAD_A;
      end
      LOAD_A, LOAD_B: begin
        enable_writing_to_mem = 1'b1;
        in_ready              = 1'b1;
        addr_pi               = AWIDTH'(row_cnt);
        if (in_valid && row_cnt == RW'(SIZE - 1))
          state_next = (state == LOAD_A) ? LOAD_B : DRAIN_WR;
      end
      DRAIN_WR: begin
        enable_writing_to_mem = 1'b1;
        if (cyc_cnt == TW'(WR_LAT - 1)) state_next = COMPUTE;
      end
      COMPUTE: begin
        // done drops start/we_c combinationally in the same cycle it arrives
        if (done_mat_mul) begin
          state_next = GAP;
        end else begin
          start_mat_mul = 1'b1;
          we_c          = 1'b1;
          if (cyc_cnt == TW'(TIMEOUT - 1)) begin
            timed_out  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      GAP: begin
        enable_reading_from_mem = 1'b1;
        state_next              = READ_C;
      end
      READ_C: begin
        enable_reading_from_mem = 1'b1;
        addr_pi                 = AWIDTH'(iss_cnt);
        issue                   = (iss_cnt < RW'(SIZE)) && credit_ok;
        if (pop && pop_cnt == RW'(SIZE - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      cyc_cnt <= '0;
      iss_cnt <= '0;
      pop_cnt <= '0;
      out_cnt <= '0;
      rd_pipe <= '0;
      wr_vld  <= '0;
      wr_isb  <= '0;
      error   <= 1'b0;
    end else begin
      if (accept) row_cnt <= (row_cnt == RW'(SIZE - 1)) ? '0 : row_cnt + 1'b1;
      if (state_next == state && (state == DRAIN_WR || state == COMPUTE))
        cyc_cnt <= cyc_cnt + 1'b1;
      else
        cyc_cnt <= '0;
      iss_cnt <= (state == READ_C) ? iss_cnt + RW'(issue) : '0;
      pop_cnt <= (state == READ_C) ? pop_cnt + RW'(pop) : '0;
      out_cnt <= out_cnt + CW'(issue) - CW'(tap);
      rd_pipe <= {rd_pipe[RD_LAT-2:0], issue};
      wr_vld  <= {wr_vld[WR_LAT-2:0], accept};
      wr_isb  <= {wr_isb[WR_LAT-2:0], (state == LOAD_B)};
      if (timed_out)                  error <= 1'b1;
      else if (state == IDLE && cmd_go) error <= 1'b0;
    end
  end

  // Row data rides alongside wr_vld; data_pi is gated so stale rows never show.
  always_ff @(posedge clk) begin
    wr_dat[0] <= in_data;
    for (int i = 1; i < WR_LAT; i++) wr_dat[i] <= wr_dat[i-1];
  end

  assign we_a    = wr_vld[WR_LAT-1] && !wr_isb[WR_LAT-1];
  assign we_b    = wr_vld[WR_LAT-1] &&  wr_isb[WR_LAT-1];
  assign data_pi = wr_vld[WR_LAT-1] ? wr_dat[WR_LAT-1] : '0;

  matmul_seq_rdfifo #(
    .WIDTH (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rdfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tap),
    .push_data (data_from_out_mat),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Scoreboard bench for matmul_host_sequencer with a behavioural C-BRAM read model.
module tb_matmul_host_sequencer;
  import matmul_host_sequencer_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 1024;

  logic              clk = 1'b0;
  logic              reset, cmd_go, in_valid, in_ready, out_valid, out_ready;
  logic              busy, error, done_mat_mul;
  logic              enable_writing_to_mem, enable_reading_from_mem;
  logic              we_a, we_b, we_c, start_mat_mul;
  logic [ROW_W-1:0]  in_data, out_data, data_pi, data_from_out_mat;
  logic [AWIDTH-1:0] addr_pi;

  typedef struct {
    int               cyc;
    logic             is_b;
    logic [ROW_W-1:0] data;
  } wr_t;

  wr_t               wq[$];
  logic [ROW_W-1:0]  cq[$];
  wr_t               wexp;
  logic [ROW_W-1:0]  c_mem [SIZE];
  logic [AWIDTH-1:0] ah [RD_LAT];
  int total = 0, bad = 0, cyc = 0;
  int acc_idx = 0, wr_cnt = 0, rd_cnt = 0, stall_issues = 0;

  matmul_host_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_go                  (cmd_go),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_data                 (in_data),
    .out_valid               (out_valid),
    .out_ready               (out_ready),
    .out_data                (out_data),
    .busy                    (busy),
    .error                   (error),
    .enable_writing_to_mem   (enable_writing_to_mem),
    .enable_reading_from_mem (enable_reading_from_mem),
    .addr_pi                 (addr_pi),
    .data_pi                 (data_pi),
    .we_a                    (we_a),
    .we_b                    (we_b),
    .we_c                    (we_c),
    .start_mat_mul           (start_mat_mul),
    .done_mat_mul            (done_mat_mul),
    .data_from_out_mat       (data_from_out_mat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // C BRAM model: data appears RD_LAT cycles after its address
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ah[0] <= addr_pi;
    for (int i = 1; i < RD_LAT; i++) ah[i] <= ah[i-1];
  end
  assign data_from_out_mat = c_mem[3'(ah[RD_LAT-1])];

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        check("acc_addr", ROW_W'(addr_pi), ROW_W'(acc_idx % SIZE));
        check("acc_in_window", ROW_W'(acc_idx < 2*SIZE), ROW_W'(1));
        wq.push_back('{cyc: cyc, is_b: (acc_idx >= SIZE), data: in_data});
        acc_idx++;
      end
      if (we_a || we_b) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          check("spurious_we", ROW_W'(1), ROW_W'(0));
        end else begin
          wexp = wq.pop_front();
          check("we_b_sel", ROW_W'(we_b), ROW_W'(wexp.is_b));
          check("we_a_sel", ROW_W'(we_a), ROW_W'(!wexp.is_b));
          check("data_pi", data_pi, wexp.data);
          check("we_latency", ROW_W'(cyc - wexp.cyc), ROW_W'(WR_LAT));
        end
      end
      if (out_valid && out_ready) begin
        rd_cnt++;
        if (cq.size() == 0) check("spurious_out", ROW_W'(1), ROW_W'(0));
        else                check("out_row", out_data, cq.pop_front());
      end
      if (!out_ready && dut.issue) stall_issues++;
    end
  end

  task automatic start_job(input bit with_reads);
    acc_idx = 0; wr_cnt = 0; rd_cnt = 0; stall_issues = 0;
    for (int i = 0; i < SIZE; i++) begin
      c_mem[i] = rand_row();
      if (with_reads) cq.push_back(c_mem[i]);
    end
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
  endtask

  task automatic load_rows(input bit toggle);
    int n = 0;
    int g = 0;
    bit acc;
    in_valid = 1'b1;
    in_data  = rand_row();
    while (n < 2*SIZE && g < 400) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      g++;
      if (acc) begin
        n++;
        in_data = rand_row();
      end
      in_valid = (n < 2*SIZE) ? (toggle ? !in_valid : 1'b1) : 1'b0;
    end
    check("rows_loaded", ROW_W'(n), ROW_W'(2*SIZE));
  endtask

  task automatic wait_start();
    int g = 0;
    while (!start_mat_mul && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("start_seen", ROW_W'(start_mat_mul), ROW_W'(1));
    check("wr_en_off", ROW_W'(enable_writing_to_mem), ROW_W'(0));
  endtask

  task automatic wait_reads();
    int g = 0;
    while (rd_cnt < SIZE && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("rows_read", ROW_W'(rd_cnt), ROW_W'(SIZE));
    @(negedge clk);
    check("idle_after_read", ROW_W'(busy), ROW_W'(0));
  endtask

  task automatic run_timeout();
    int n = 0;
    int g = 0;
    while (busy && g < TIMEOUT + 200) begin
      if (start_mat_mul) n++;
      @(negedge clk);
      g++;
    end
    check("timeout_len", ROW_W'(n), ROW_W'(TIMEOUT));
    check("timeout_error", ROW_W'(error), ROW_W'(1));
    check("timeout_idle", ROW_W'(busy), ROW_W'(0));
  endtask

  initial begin
    reset = 1'b1; cmd_go = 1'b1; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; done_mat_mul = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", ROW_W'(busy), ROW_W'(0));
    check("rst_in_ready", ROW_W'(in_ready), ROW_W'(0));
    check("rst_out_valid", ROW_W'(out_valid), ROW_W'(0));
    check("rst_error", ROW_W'(error), ROW_W'(0));
    check("rst_en_wr", ROW_W'(enable_writing_to_mem), ROW_W'(0));
    check("rst_en_rd", ROW_W'(enable_reading_from_mem), ROW_W'(0));
    check("rst_addr", ROW_W'(addr_pi), ROW_W'(0));
    check("rst_data_pi", data_pi, '0);
    check("rst_out_data", out_data, '0);
    check("rst_we", ROW_W'({we_a, we_b, we_c, start_mat_mul}), ROW_W'(0));
    @(posedge clk); #1 reset = 1'b0; cmd_go = 1'b0;
    @(negedge clk);
    check("go_in_reset", ROW_W'(busy), ROW_W'(0));

    // Job 1: back-to-back load, late done, stalled read-out
    start_job(1'b1);
    load_rows(1'b0);
    wait_start();
    repeat (10) @(posedge clk);
    #1 cmd_go = 1'b1;
    @(negedge clk);
    check("go_ignored", ROW_W'(start_mat_mul), ROW_W'(1));
    @(posedge clk); #1 cmd_go = 1'b0;
    repeat (9) @(posedge clk);
    #1 done_mat_mul = 1'b1;
    @(negedge clk);
    check("start_drop", ROW_W'(start_mat_mul), ROW_W'(0));
    check("we_c_drop", ROW_W'(we_c), ROW_W'(0));
    check("rd_en_not_yet", ROW_W'(enable_reading_from_mem), ROW_W'(0));
    @(posedge clk); #1 done_mat_mul = 1'b0;
    @(negedge clk);
    check("rd_en_rise", ROW_W'(enable_reading_from_mem), ROW_W'(1));
    check("wr_count_1", ROW_W'(wr_cnt), ROW_W'(2*SIZE));
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_valid", ROW_W'(out_valid), ROW_W'(1));
    check("stall_issue_cap", ROW_W'(stall_issues <= FIFO_DEPTH), ROW_W'(1));
    check("stall_no_pop", ROW_W'(rd_cnt), ROW_W'(0));
    @(posedge clk); #1 out_ready = 1'b1;
    wait_reads();

    // Job 2: gappy load, extra rows back-pressured, quick done
    start_job(1'b1);
    load_rows(1'b1);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("backpressure", ROW_W'(in_ready), ROW_W'(0));
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_start();
    repeat (3) @(posedge clk);
    #1 done_mat_mul = 1'b1;
    @(posedge clk); #1 done_mat_mul = 1'b0;
    wait_reads();
    check("wr_count_2", ROW_W'(wr_cnt), ROW_W'(2*SIZE));

    // Job 3: no done -> timeout, then cmd_go clears error, then reset aborts
    start_job(1'b0);
    load_rows(1'b0);
    wait_start();
    run_timeout();
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
    @(negedge clk);
    check("error_cleared", ROW_W'(error), ROW_W'(0));
    check("busy_after_go", ROW_W'(busy), ROW_W'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_idle", ROW_W'(busy), ROW_W'(0));
    check("abort_en_wr", ROW_W'(enable_writing_to_mem), ROW_W'(0));
    check("wq_empty", ROW_W'(wq.size()), ROW_W'(0));
    check("cq_empty", ROW_W'(cq.size()), ROW_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
